uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Frame controller between the UART core's FIFO interface and the combinational ALU. It pops a three-byte command frame (operand A, operand B, opcode) from the RX FIFO and presents the registered operands to the ALU. It captures the result and pushes it as one byte into the TX FIFO. It validates opcodes, drops partial frames on an inter-byte timeout, and reports frame errors.

## Interface
- DBIT, 8, data/operand width in bits; matches the UART word width
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte
- TIMEOUT, 500000, clock cycles allowed between bytes of one frame; 0 disables the timeout
- TO_BITS, 19, timeout counter width; 2^TO_BITS > TIMEOUT
- ERR_CODE, 8'hEE, byte sent instead of a result on an invalid opcode

- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- rx_empty  in  1  RX FIFO empty
- r_data  in  DBIT  RX FIFO head word; valid whenever rx_empty=0 (fall-through)
- rd_uart  out  1  RX FIFO pop, one-cycle pulse
- tx_full  in  1  TX FIFO full
- w_data  out  DBIT  byte to TX FIFO
- wr_uart  out  1  TX FIFO push, one-cycle pulse
- alu_a, alu_b  out  DBIT  registered operands
- alu_op  out  NB_OP  registered opcode
- alu_result  in  DBIT  combinational ALU result
- busy  out  1  high in every state except RD_A
- done_tick  out  1  one-cycle pulse when a valid result is pushed
- err_tick  out  1  one-cycle pulse on invalid opcode or timeout

## Operation
- States: RD_A, RD_B, RD_OP, EXEC, SEND.
- RD_A:
  - If rx_empty=0: assert rd_uart, load alu_a <= r_data, go to RD_B.
  - No timeout in this state.
- RD_B: same pop behaviour, loading alu_b; on a pop, go to RD_OP.
- RD_OP: on a pop, load alu_op <= r_data[NB_OP-1:0] and go to EXEC.
  - Upper bits of the byte are ignored.
- Timeout (RD_B and RD_OP only):
  - Counter clears on entry to each state and on every pop.
  - It increments each cycle while rx_empty=1.
  - When it reaches TIMEOUT-1 with rx_empty still 1: pulse err_tick, go to RD_A, discard the partial frame.
- Valid opcodes:
  - 6'b100000 ADD, 6'b100010 SUB, 6'b100100 AND, 6'b100101 OR
  - 6'b100110 XOR, 6'b100111 NOR, 6'b000011 SRA, 6'b000010 SRL
- EXEC (one cycle):
  - Valid opcode: result register <= alu_result.
  - Invalid opcode: result register <= ERR_CODE, set an internal err flag.
  - Always go to SEND.
- SEND:
  - While tx_full=1: hold; w_data stays stable and wr_uart stays 0.
  - When tx_full=0: assert wr_uart for one cycle, w_data = result register, go to RD_A.
  - In that same cycle, pulse done_tick (valid opcode) or err_tick (invalid opcode).
- w_data, alu_a, alu_b and alu_op are registers. They hold their values until overwritten.
- rd_uart and wr_uart are never high in the same cycle.

## Timing
- Reset values:
  - state RD_A
  - rd_uart, wr_uart, done_tick, err_tick, busy = 0
  - w_data, alu_a, alu_b, alu_op, result register = 0
  - timeout counter = 0
- Reset mid-frame returns to RD_A immediately.
  - Captured bytes are lost.
  - This block does not affect bytes already in the FIFOs.
- Every pop takes exactly one cycle. The next pop in the following state can occur on the next cycle if rx_empty=0.
- With all three bytes already queued and tx_full=0:
  - rd_uart is high in cycles 0, 1, 2.
  - EXEC occurs in cycle 3.
  - wr_uart is high in cycle 4.
  - busy is high during cycles 1–4 and low in cycle 5.
- alu_op changes at the end of cycle 2, so alu_result has one full cycle (cycle 3) to settle before capture.
- A timeout triggers in the cycle where the counter equals TIMEOUT-1. The state is RD_A on the next cycle.

## Test plan
- Queue 0x05, 0x03, 0x20 with tx_full=0 -> rd_uart pulses in 3 consecutive cycles, then 2 cycles later wr_uart=1 with w_data=0x08 and done_tick=1.
- Queue 0x03, 0x05, 0x22 (SUB) while holding tx_full=1 for 10 cycles -> SEND holds, w_data=0xFE stays stable, wr_uart stays 0 until tx_full drops, then exactly one push.
- Queue 0xAA, 0x0F, 0x3F (invalid opcode) -> wr_uart with w_data=0xEE, err_tick=1, done_tick=0.
- With TIMEOUT=16: send 0x12 only -> after 16 empty cycles, err_tick=1 and busy=0. A following frame 0x0C, 0x0A, 0x24 returns 0x08.
- Assert reset in RD_OP after two bytes are popped -> all outputs return to reset values. The next full frame 0x01, 0x02, 0x20 returns 0x03.
- Queue 0x81, 0x01, 0x03 (SRA) then 0x81, 0x01, 0x02 (SRL) back-to-back -> two pushes, 0xC0 then 0x40, in order.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// Frame controller between UART FIFOs and a combinational ALU.
// Pops A, B, opcode; pushes one result byte or an error code.
module uart_alu_ctrl #(
  parameter int DBIT = 8,
  parameter int NB_OP = 6,
  parameter int TIMEOUT = 500000,
  parameter int TO_BITS = 19,
  parameter logic [DBIT-1:0] ERR_CODE = 8'hEE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [DBIT-1:0]  w_data,
  output logic             wr_uart,
  output logic [DBIT-1:0]  alu_a,
  output logic [DBIT-1:0]  alu_b,
  output logic [NB_OP-1:0] alu_op,
  input  logic [DBIT-1:0]  alu_result,
  output logic             busy,
  output logic             done_tick,
  output logic             err_tick
);

  typedef enum logic [2:0] {
    RD_A, RD_B, RD_OP, EXEC, SEND
  } state_t;

  localparam logic [TO_BITS-1:0] TO_LAST =
    TO_BITS'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT > 0);

  state_t state_q, state_d;
  logic [TO_BITS-1:0] to_q;
  logic [DBIT-1:0] result_q;
  logic err_q;
  logic pop;
  logic to_hit;
  logic op_ok;

  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    logic [5:0] o;
    o = 6'(op);
    unique case (o)
      6'b100000, 6'b100010,
      6'b100100, 6'b100101,
      6'b100110, 6'b100111,
      6'b000011, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign op_ok = op_valid(alu_op);
  assign to_hit = TO_EN && rx_empty && (to_q == TO_LAST);
  assign busy = (state_q != RD_A);
  assign w_data = result_q;
  // Fall-through FIFO: the pop strobe is combinational on rx_empty
  assign rd_uart = pop & ~reset;

  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    wr_uart = 1'b0;
    done_tick = 1'b0;
    err_tick = 1'b0;
    unique case (state_q)
      RD_A: begin
        if (!rx_empty) begin
          pop = 1'b1;
          state_d = RD_B;
        end
      end
      RD_B: begin
        if (!rx_empty) begin
          pop = 1'b1;
          state_d = RD_OP;
        end else if (to_hit) begin
          err_tick = 1'b1;
          state_d = RD_A;
        end
      end
      RD_OP: begin
        if (!rx_empty) begin
          pop = 1'b1;
          state_d = EXEC;
        end else if (to_hit) begin
          err_tick = 1'b1;
          state_d = RD_A;
        end
      end
      EXEC: state_d = SEND;
      SEND: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          done_tick = ~err_q;
          err_tick = err_q;
          state_d = RD_A;
        end
      end
      default: state_d = RD_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RD_A;
      to_q <= '0;
      result_q <= '0;
      err_q <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
    end else begin
      state_q <= state_d;
      if (pop && state_q == RD_A) alu_a <= r_data;
      if (pop && state_q == RD_B) alu_b <= r_data;
      if (pop && state_q == RD_OP) alu_op <= r_data[NB_OP-1:0];
      if (state_q == EXEC) begin
        result_q <= op_ok ? alu_result : ERR_CODE;
        err_q <= ~op_ok;
      end
      // Cleared on every state change and every pop
      if (state_d != state_q || pop) begin
        to_q <= '0;
      end else if (rx_empty &&
                   (state_q == RD_B || state_q == RD_OP)) begin
        to_q <= to_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl with a fall-through RX FIFO model
// and a behavioural ALU.
module tb_uart_alu_ctrl;

  logic clk = 0;
  logic reset = 1;
  logic rx_empty;
  logic [7:0] r_data;
  logic rd_uart;
  logic tx_full = 0;
  logic [7:0] w_data;
  logic wr_uart;
  logic [7:0] alu_a, alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic busy, done_tick, err_tick;

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .DBIT(8), .NB_OP(6), .TIMEOUT(16), .TO_BITS(5), .ERR_CODE(8'hEE)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy),
    .done_tick(done_tick), .err_tick(err_tick)
  );

  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      6'b100000: alu_result = alu_a + alu_b;
      6'b100010: alu_result = alu_a - alu_b;
      6'b100100: alu_result = alu_a & alu_b;
      6'b100101: alu_result = alu_a | alu_b;
      6'b100110: alu_result = alu_a ^ alu_b;
      6'b100111: alu_result = ~(alu_a | alu_b);
      6'b000011: alu_result = 8'($signed(alu_a) >>> alu_b);
      6'b000010: alu_result = alu_a >> alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  logic [7:0] rx_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rx_empty = (wr_ptr == rd_ptr);
  assign r_data = rx_mem[rd_ptr[5:0]];
  always @(posedge clk) if (rd_uart) rd_ptr <= rd_ptr + 1;

  typedef struct {
    int kind;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int n_checks = 0;
  int n_fail = 0;
  int n_push = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (wr_uart || err_tick)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: wr=%0b err=%0b w_data=%0h expected none",
                 wr_uart, err_tick, w_data);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == 2) begin
          check("timeout_no_push", 32'(wr_uart), 0);
          check("timeout_err", 32'(err_tick), 1);
        end else begin
          n_push++;
          check("w_data", 32'(w_data), 32'(e.data));
          check("done_tick", 32'(done_tick), 32'(e.kind == 0));
          check("err_tick", 32'(err_tick), 32'(e.kind == 1));
          check("rd_wr_excl", 32'(rd_uart), 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_out(input int kind, input logic [7:0] d);
    exp_t x;
    x.kind = kind;
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op);
    rx_push(a);
    rx_push(b);
    rx_push(op);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
    step();
    step();
  endtask

  logic [5:0] rd_seq, wr_seq, busy_seq;
  int wr_cnt, prev_push, hit;

  initial begin
    repeat (3) step();
    @(negedge clk);
    check("rst_rd_uart", 32'(rd_uart), 0);
    check("rst_wr_uart", 32'(wr_uart), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_w_data", 32'(w_data), 0);
    check("rst_alu_ops", {8'h0, alu_a, alu_b, 2'b0, alu_op}, 0);
    check("rst_ticks", {done_tick, err_tick}, 0);
    step();
    reset = 0;
    step();

    // ADD with cycle-accurate timing
    frame(8'h05, 8'h03, 8'h20);
    expect_out(0, 8'h08);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rd_seq[c] = rd_uart;
      wr_seq[c] = wr_uart;
      busy_seq[c] = busy;
    end
    check("add_rd_timing", 32'(rd_seq), 32'(6'b000111));
    check("add_wr_timing", 32'(wr_seq), 32'(6'b010000));
    check("add_busy_timing", 32'(busy_seq), 32'(6'b011110));
    drain("add_drain");

    // SUB with TX back-pressure
    tx_full = 1;
    prev_push = n_push;
    frame(8'h03, 8'h05, 8'h22);
    expect_out(0, 8'hFE);
    wr_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr_uart) wr_cnt++;
    end
    check("hold_no_wr", 32'(wr_cnt), 0);
    check("hold_w_data", 32'(w_data), 32'hFE);
    check("hold_busy", 32'(busy), 1);
    step();
    tx_full = 0;
    repeat (3) @(negedge clk);
    check("hold_one_push", 32'(n_push), 32'(prev_push + 1));
    drain("sub_drain");

    // invalid opcode
    frame(8'hAA, 8'h0F, 8'h3F);
    expect_out(1, 8'hEE);
    drain("inv_drain");

    // inter-byte timeout
    rx_push(8'h12);
    expect_out(2, 8'h00);
    hit = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (err_tick) begin
        hit = c;
        break;
      end
    end
    check("timeout_cycle", 32'(hit), 16);
    @(negedge clk);
    check("timeout_busy", 32'(busy), 0);
    step();
    frame(8'h0C, 8'h0A, 8'h24);
    expect_out(0, 8'h08);
    drain("to_next_drain");

    // reset in RD_OP
    rx_push(8'h01);
    rx_push(8'h02);
    repeat (4) @(negedge clk);
    check("pre_rst_alu_b", 32'(alu_b), 32'h02);
    step();
    reset = 1;
    @(negedge clk);
    check("mid_rst_alu", {16'h0, alu_a, alu_b}, 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_w_data", 32'(w_data), 0);
    check("mid_rst_rd", 32'(rd_uart), 0);
    step();
    reset = 0;
    step();
    frame(8'h01, 8'h02, 8'h20);
    expect_out(0, 8'h03);
    drain("rst_next_drain");

    // back-to-back shifts
    frame(8'h81, 8'h01, 8'h03);
    frame(8'h81, 8'h01, 8'h02);
    expect_out(0, 8'hC0);
    expect_out(0, 8'h40);
    drain("shift_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
